// File: rtl/issue_select_pkg.sv
// Shared types for the issue-select slice: micro-op layout and default sizing.
package issue_pkg;

  localparam int DefSize = 16;
  localparam int DefTags = 64;
  localparam int TagW    = $clog2(DefTags);

  typedef struct packed {
    logic [TagW-1:0] src1_tag;
    logic            src1_used;
    logic [TagW-1:0] src2_tag;
    logic            src2_used;
    logic [TagW-1:0] dest_tag;
    logic [7:0]      opcode;
  } uop_t;

endpackage

// File: rtl/issue_select_if.sv
// Valid/ready hand-off of one micro-op from the select stage to a functional unit.
interface issue_select_if;
  import issue_pkg::*;

  logic valid;
  uop_t data;
  logic ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/issue_select_prio_pick.sv
// Lowest-index-first priority pick over a request mask; yields found plus a one-hot grant.
module prio_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_req,
  output logic         o_found,
  output logic [N-1:0] o_onehot
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_req & (~i_req + N'(1));
  assign o_found  = |i_req;

endmodule

// File: rtl/issue_select.sv
// Picks the oldest operand-ready queue entry each cycle and holds it in a valid/ready stage.
module issue_select
  import issue_pkg::*;
#(
  parameter int Size = DefSize,
  parameter int Tags = DefTags,
  localparam int Width    = $clog2(Size),
  localparam int TagWidth = $clog2(Tags)
) (
  input  logic                clk_ni,
  input  logic                rst_i,
  input  logic [Width:0]      size_i,
  input  uop_t                entries_i [Size],
  output logic [Size-1:0]     pop_o,
  input  logic                alloc_valid_i,
  input  logic [TagWidth-1:0] alloc_tag_i,
  input  logic                wakeup_valid_i,
  input  logic [TagWidth-1:0] wakeup_tag_i,
  input  logic                flush_i,
  issue_select_if.master      issue_if
);

  logic [Tags-1:0] r_sb;
  logic            r_valid;
  uop_t            r_data;

  logic [Tags-1:0] w_sbNext;
  logic [Size-1:0] w_eligible;
  logic [Size-1:0] w_onehot;
  logic            w_found;
  logic            w_canAccept;
  logic            w_pickEn;
  uop_t            w_pickData;

  // Eligibility reads the scoreboard as it stood before this edge: no wakeup bypass.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < Size; i++) begin
      w_eligible[i] = ((Width+1)'(i) < size_i)
                    && (!entries_i[i].src1_used || r_sb[entries_i[i].src1_tag])
                    && (!entries_i[i].src2_used || r_sb[entries_i[i].src2_tag]);
    end
  end

  prio_pick #(.N(Size)) u_pick (
    .i_req    (w_eligible),
    .o_found  (w_found),
    .o_onehot (w_onehot)
  );

  assign w_canAccept = !r_valid || issue_if.ready;
  assign w_pickEn    = w_found && w_canAccept && !flush_i && !rst_i;
  assign pop_o       = w_pickEn ? w_onehot : '0;

  always_comb begin
    w_pickData = '0;
    for (int i = 0; i < Size; i++) begin
      if (w_onehot[i]) w_pickData = uop_t'(w_pickData | entries_i[i]);
    end
  end

  // Alloc is applied last so it wins over a same-tag wakeup.
  always_comb begin
    w_sbNext = r_sb;
    if (wakeup_valid_i) w_sbNext[wakeup_tag_i] = 1'b1;
    if (alloc_valid_i)  w_sbNext[alloc_tag_i]  = 1'b0;
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      r_sb    <= '1;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sb <= w_sbNext;
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_pickEn) begin
        r_valid <= 1'b1;
        r_data  <= w_pickData;
      end else if (issue_if.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign issue_if.valid = r_valid;
  assign issue_if.data  = r_data;

endmodule

// File: tb/tb_issue_select.sv
// Randomised scoreboard bench for issue_select against a queue-level reference model.
module tb_issue_select;
  import issue_pkg::*;

  localparam int Size = 16;

  logic       clk_ni;
  logic       rst_i;
  logic [4:0] size_i;
  uop_t       entries_i [Size];
  logic [15:0] pop_o;
  logic       alloc_valid_i;
  logic [5:0] alloc_tag_i;
  logic       wakeup_valid_i;
  logic [5:0] wakeup_tag_i;
  logic       flush_i;

  issue_select_if ifc ();

  issue_select dut (
    .clk_ni         (clk_ni),
    .rst_i          (rst_i),
    .size_i         (size_i),
    .entries_i      (entries_i),
    .pop_o          (pop_o),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_tag_i    (alloc_tag_i),
    .wakeup_valid_i (wakeup_valid_i),
    .wakeup_tag_i   (wakeup_tag_i),
    .flush_i        (flush_i),
    .issue_if       (ifc)
  );

  initial begin
    clk_ni = 1'b0;
    forever #5 clk_ni = ~clk_ni;
  end

  uop_t        q[$];
  uop_t        expQ[$];
  logic [63:0] mSb;
  bit          mValid;
  uop_t        mData;
  int          nCmp;
  int          nFail;
  bit          done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t randUop(input bit indep);
    uop_t u;
    u.src1_tag  = 6'($urandom_range(0, 15));
    u.src2_tag  = 6'($urandom_range(0, 15));
    u.src1_used = indep ? 1'b0 : 1'($urandom_range(0, 1));
    u.src2_used = indep ? 1'b0 : 1'($urandom_range(0, 1));
    u.dest_tag  = 6'($urandom_range(0, 63));
    u.opcode    = 8'($urandom_range(0, 255));
    return u;
  endfunction

  function automatic uop_t depUop(input logic [5:0] tag);
    uop_t u;
    u = randUop(1'b1);
    u.src1_used = 1'b1;
    u.src1_tag  = tag;
    return u;
  endfunction

  // One clock of stimulus: drive at posedge, check combinational pop, then advance the model past the negedge.
  task automatic applyStimulus(input bit rstV, input bit flushV, input bit readyV,
                               input bit allocV, input logic [5:0] allocT,
                               input bit wakeV, input logic [5:0] wakeT);
    int   pickIdx;
    int   n;
    uop_t e;
    logic [15:0] expPop;
    @(posedge clk_ni);
    rst_i          = rstV;
    flush_i        = flushV;
    ifc.ready      = readyV;
    alloc_valid_i  = allocV;
    alloc_tag_i    = allocT;
    wakeup_valid_i = wakeV;
    wakeup_tag_i   = wakeT;
    n = (q.size() > Size) ? Size : q.size();
    size_i = 5'(n);
    for (int i = 0; i < Size; i++) entries_i[i] = (i < n) ? q[i] : randUop(1'b0);
    #1;
    pickIdx = -1;
    if (!rstV && !flushV && (!mValid || readyV)) begin
      for (int i = 0; i < n; i++) begin
        e = q[i];
        if ((!e.src1_used || mSb[e.src1_tag]) && (!e.src2_used || mSb[e.src2_tag])) begin
          pickIdx = i;
          break;
        end
      end
    end
    expPop = (pickIdx >= 0) ? (16'(1) << pickIdx) : 16'(0);
    checkOutput("pop", 32'(pop_o), 32'(expPop));
    checkOutput("valid", 32'(ifc.valid), 32'(mValid));
    if (mValid && readyV) expQ.push_back(mData);
    if (rstV) begin
      mSb    = '1;
      mValid = 1'b0;
      mData  = '0;
    end else begin
      if (wakeV)  mSb[wakeT]  = 1'b1;
      if (allocV) mSb[allocT] = 1'b0;
      if (flushV) mValid = 1'b0;
      else if (pickIdx >= 0) begin
        mValid = 1'b1;
        mData  = q[pickIdx];
      end else if (readyV) mValid = 1'b0;
    end
    if (pickIdx >= 0) q.delete(pickIdx);
  endtask

  task automatic idle(input int cycles, input bit readyV);
    for (int c = 0; c < cycles; c++) applyStimulus(0, 0, readyV, 0, 6'd0, 0, 6'd0);
  endtask

  // Monitor: every accepted transfer must match the next op the model expects to hand off.
  initial begin
    uop_t exp;
    forever begin
      @(posedge clk_ni);
      #2;
      if (done) break;
      if (ifc.valid === 1'b1 && ifc.ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected-transfer", 32'(ifc.data), 32'hFFFF_FFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("data", 32'(ifc.data), 32'(exp));
        end
      end
    end
  end

  initial begin
    nCmp = 0; nFail = 0; done = 0;
    mSb = '1; mValid = 0; mData = '0;
    rst_i = 1; flush_i = 0; ifc.ready = 0;
    alloc_valid_i = 0; alloc_tag_i = '0; wakeup_valid_i = 0; wakeup_tag_i = '0;
    size_i = '0;
    for (int i = 0; i < Size; i++) entries_i[i] = '0;
    repeat (2) @(negedge clk_ni);

    applyStimulus(1, 0, 1, 0, 6'd0, 0, 6'd0);
    for (int i = 0; i < 3; i++) q.push_back(randUop(1'b1));
    idle(5, 1);

    applyStimulus(0, 0, 1, 1, 6'd5, 0, 6'd0);
    q.push_back(depUop(6'd5));
    q.push_back(randUop(1'b1));
    idle(3, 1);
    applyStimulus(0, 0, 1, 0, 6'd0, 1, 6'd5);
    idle(3, 1);

    for (int i = 0; i < 4; i++) q.push_back(randUop(1'b1));
    idle(1, 1);
    idle(4, 0);
    idle(5, 1);

    applyStimulus(0, 0, 1, 1, 6'd9, 1, 6'd9);
    q.push_back(depUop(6'd9));
    idle(3, 1);
    applyStimulus(0, 0, 1, 0, 6'd0, 1, 6'd9);
    idle(3, 1);

    for (int i = 0; i < 4; i++) q.push_back(randUop(1'b1));
    idle(1, 0);
    applyStimulus(0, 1, 0, 0, 6'd0, 0, 6'd0);
    idle(6, 1);

    for (int c = 0; c < 1500; c++) begin
      if (q.size() < 20 && $urandom_range(0, 1) == 1) begin
        q.push_back(randUop(1'b0));
        if ($urandom_range(0, 2) == 0) q.push_back(randUop(1'b0));
      end
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, 6'($urandom_range(0, 15)),
                    $urandom_range(0, 4) < 3,  6'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 3; i++) q.push_back(randUop(1'b1));
    idle(1, 0);
    applyStimulus(1, 0, 0, 1, 6'd3, 0, 6'd0);
    q.push_back(depUop(6'd3));
    idle(4, 1);

    #2;
    done = 1;
    checkOutput("expq-drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
